// File: rtl/stream_fetch.sv
// Memory-to-stream fetch engine: AXI4 INCR read bursts into a word FIFO, drained as one AXI-Stream packet.
// Optional build macro STREAM_FETCH_4K_SPLIT_EN keeps every burst inside a single 4 KB page.
module stream_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int PW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  seen_q, seen_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] lastv_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           cnt_q;

    logic [31:0] blen;
    logic        credit_ok;
    logic        beat, full, pop, push_ok;

    // Burst length L from the words left, the burst cap and (optionally) the 4 KB page end.
    always_comb begin
        blen = (32'(rem_q) > 32'(MAX_BURST)) ? 32'(MAX_BURST) : 32'(rem_q);
`ifdef STREAM_FETCH_4K_SPLIT_EN
        if (((32'd4096 - (32'(addr_q) & 32'hFFF)) >> BSHIFT) < blen)
            blen = (32'd4096 - (32'(addr_q) & 32'hFFF)) >> BSHIFT;
`else
`endif
        credit_ok = (32'(FIFO_DEPTH) - 32'(cnt_q)) >= blen;
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign araddr   = addr_q;
    assign arvalid  = (state_q == ADDR) && credit_ok;
    assign arlen    = (state_q == ADDR) ? 8'(blen - 32'd1) : 8'd0;
    assign rready   = (state_q == DATA);

    assign m_tvalid = (cnt_q != '0);
    assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_tlast  = m_tvalid & lastv_q[rd_ptr_q];

    assign full     = cnt_q[PW];
    assign pop      = m_tvalid && m_tready;
    assign beat     = (state_q == DATA) && rvalid;
    assign push_ok  = beat && (!full || pop);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        done_d  = 1'b0;
        seen_d  = seen_q || (pop && m_tlast);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != 16'd0) begin
                        addr_d  = base_addr & ~ADDR_WIDTH'(BYTES - 1);
                        rem_d   = num_words;
                        err_d   = 1'b0;
                        seen_d  = 1'b0;
                        state_d = ADDR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (arvalid && arready) begin
                    addr_d  = addr_q + ADDR_WIDTH'(blen << BSHIFT);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    rem_d = (rem_q == 16'd0) ? 16'd0 : rem_q - 16'd1;
                    if (rresp != 2'b00) err_d = 1'b1;
                    if (rlast) state_d = (rem_d != 16'd0) ? ADDR : DRAIN;
                end
            end
            DRAIN: begin
                // Finish once the tagged last word has left and nothing else is queued.
                if ((pop && m_tlast && cnt_q == (PW+1)'(1)) || (seen_q && cnt_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            seen_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
            seen_q  <= seen_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // The beat counter, not rlast, tags the final word of the packet.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q]   <= rdata;
            lastv_q[wr_ptr_q] <= (rem_q == 16'd1);
        end
    end
endmodule

// File: doc/stream_fetch.md
# stream_fetch

Memory-to-stream fetch engine feeding the accelerator's input stream. On a start command it reads a contiguous block of words from accelerator memory using AXI4 incrementing read bursts and emits them, in order, as an AXI-Stream packet with `tlast` on the final word. It sits between the accelerator memory bus and the accelerator's input stream, upstream of `hw_accel`. Its command, status and error bits are mapped through the control register block.

## Interface
- `ADDR_WIDTH`, 16, byte address width of the memory bus.
- `DATA_WIDTH`, 32, word width for both the memory bus and the stream; power of two, at least 8.
- `MAX_BURST`, 16, maximum beats per burst; range 1..256.
- `FIFO_DEPTH`, 32, depth of the internal word FIFO; power of two, at least `MAX_BURST`.

Ports:
- `aclk` in 1: single clock for the whole block.
- `aresetn` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle command pulse.
- `base_addr` in ADDR_WIDTH: start byte address; low log2(DATA_WIDTH/8) bits are ignored (treated as 0).
- `num_words` in 16: number of words to transfer.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky; set on any `rresp` other than OKAY.
- `araddr` out ADDR_WIDTH, `arlen` out 8, `arvalid` out 1, `arready` in 1: AXI read-address channel. `arsize` is fixed at log2(DATA_WIDTH/8); `arburst` is fixed at INCR.
- `rdata` in DATA_WIDTH, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read-data channel.
- `m_tdata` out DATA_WIDTH, `m_tlast` out 1, `m_tvalid` out 1, `m_tready` in 1: output stream.

## Operation
- FSM states: IDLE, ADDR, DATA, DRAIN.
- **IDLE:**
  - If `start`=1 and `num_words`>0: latch the address and the word count, clear `err`, and go to ADDR.
  - If `start`=1 and `num_words`=0: pulse `done` on the next cycle and stay in IDLE. No bus traffic is generated.
  - `start` outside IDLE is ignored.
- **ADDR:**
  - Burst length is L = min(MAX_BURST, remaining words, words left before the next 4 KB boundary [see Configuration]).
  - Wait until FIFO free space is at least L. Then assert `arvalid` with `arlen`=L-1.
  - Hold `araddr` and `arlen` stable until `arready`, then go to DATA.
- **DATA:**
  - `rready`=1 throughout; overflow is impossible because of the credit check in ADDR.
  - Each R beat is pushed into the FIFO and decrements the remaining count.
  - If `rresp`≠0, set `err`. Data is still forwarded.
  - On `rlast`: go to ADDR if words remain, otherwise go to DRAIN.
  - Only one burst is outstanding at a time.
- **DRAIN:** wait until the FIFO is empty and the last word has been accepted. Then pulse `done`, deassert `busy`, and go to IDLE.
- **Address arithmetic:**
  - Next `araddr` = `araddr` + L·(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
  - Wrap past the top of the address space is allowed and silent.
- **Stream side:**
  - FIFO head drives `m_tdata`.
  - `m_tlast`=1 exactly on word `num_words` of the transfer.
  - A mismatched `rlast` (early or late relative to `arlen`) is not checked. The FSM trusts `rlast`, and the beat counter alone decides `m_tlast`.

## Timing
- **Reset values:** `busy`, `done`, `err`, `arvalid`, `rready`, `m_tvalid`, `m_tlast` = 0; `araddr`, `arlen`, `m_tdata` = 0. FSM in IDLE, FIFO empty.
- **Reset mid-transfer** aborts immediately and returns to the reset values. Any outstanding AXI burst is abandoned; the interconnect is reset together with this block.
- **Command to address:** `start` at cycle 0 gives `busy`=1 and `arvalid`=1 at cycle 1, provided the FIFO credit is available.
- **R to stream:** an R beat accepted at cycle n appears on `m_tvalid` at cycle n+1, provided the FIFO was empty.
- **Throughput:** one word per cycle while `m_tready`=1 and memory streams. Each burst turnaround costs at least one idle cycle on the AR channel.
- **Backpressure:** `m_tvalid`/`m_tdata`/`m_tlast` stay stable while `m_tready`=0.
- **Simultaneous push and pop** on a full FIFO: both occur and the occupancy is unchanged.
- **Completion:** `done` is asserted in the cycle after the handshake that carries `m_tlast`. `busy` falls in that same cycle.

## Configuration
- Macro: `STREAM_FETCH_4K_SPLIT_EN`.
- **Defined:** bursts never cross a 4 KB address boundary; L is additionally capped at (4096 − (`araddr` mod 4096))/(DATA_WIDTH/8).
- **Undefined:** the boundary term is dropped; L = min(MAX_BURST, remaining).
- The word order and the `m_tlast` position are identical in both builds.

## Test plan
- **Zero length:** `start`, `num_words`=0 → `done` at cycle 1, `arvalid` never asserted, `busy` stays 0.
- **Split into bursts:** `base_addr`=0x0100, `num_words`=40, MAX_BURST=16 → ARs at 0x0100/0x0140/0x0180 with `arlen` 15/15/7. The stream carries 40 words in order, with `m_tlast` on word 40 only.
- **4 KB split:** `base_addr`=0x0FF0, `num_words`=8, macro defined → ARs at 0x0FF0 with `arlen`=3 and at 0x1000 with `arlen`=3. With the macro undefined → a single AR with `arlen`=7.
- **Backpressure:** `m_tready` toggled at random, 64 words → no words lost or duplicated, `rready` never stalls a burst, the FIFO never overflows.
- **Error response:** SLVERR on beat 5 of 16 → all 16 words are streamed, `err`=1 after the transfer and still 1 after `done`, cleared by the next `start`.
- **Reset mid-burst:** `aresetn` low during beat 3 → all outputs at their reset values within the same cycle. A new 4-word transfer then completes normally.
